// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// a registered fill level, sticky overflow/underflow flags and a choice of
// standard (registered) or first-word-fall-through read behaviour.
module sync_fifo_prog #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter bit          FWFT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic [ADDR_WIDTH:0]   aempty_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // Level encoding of a completely full FIFO: only the top bit set.
    localparam logic [ADDR_WIDTH:0]   LEVEL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   LEVEL_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic wr_ok;
    logic rd_ok;

    // Status decode from the registered level; thresholds compared live.
    always_comb begin
        full         = (level_q == LEVEL_FULL);
        empty        = (level_q == '0);
        almost_full  = (level_q >= afull_thresh);
        almost_empty = (level_q <= aempty_thresh);
        level        = level_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    // Accept decisions use this cycle's full/empty, so a read frees no space
    // for a same-cycle write and a write gives nothing to a same-cycle read.
    always_comb begin
        wr_ok = wr_en & ~full;
        rd_ok = rd_en & ~empty;
    end

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_ok) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + PTR_ONE;
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase

        // A new error in the same cycle as clr_err keeps the flag set.
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end

        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr_q] <= wr_data;
        end
    end

    if (FWFT) begin : g_fwft
        // Head word is presented directly whenever the FIFO holds data.
        always_comb begin
            rd_valid = ~empty;
            rd_data  = mem[rptr_q];
        end
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        // Registered read port: popped word appears one cycle after rd_en.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_ok;
                if (rd_ok) begin
                    rd_data_q <= mem[rptr_q];
                end
            end
        end

        // Drive the output ports from the read registers.
        always_comb begin
            rd_valid = rd_valid_q;
            rd_data  = rd_data_q;
        end
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench: one standard-mode and one FWFT instance share the
// same stimulus and are both compared every cycle against a queue model.
module tb_sync_fifo_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       clr_err;
    logic [6:0] afull_thresh;
    logic [6:0] aempty_thresh;

    logic [7:0] s_rd_data, f_rd_data;
    logic       s_rd_valid, f_rd_valid;
    logic       s_full, f_full, s_empty, f_empty;
    logic       s_afull, f_afull, s_aempty, f_aempty;
    logic [6:0] s_level, f_level;
    logic       s_ovf, f_ovf, s_udf, f_udf;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .FWFT(1'b0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
        .almost_full(s_afull), .almost_empty(s_aempty), .level(s_level),
        .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err)
    );

    sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
        .almost_full(f_afull), .almost_empty(f_aempty), .level(f_level),
        .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] q[$];
    bit         ovf_m;
    bit         udf_m;
    bit         sv_m;
    logic [7:0] sd_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("s_level", 32'(s_level), n);
        chk("f_level", 32'(f_level), n);
        chk("s_full", 32'(s_full), 32'(n == 64));
        chk("f_full", 32'(f_full), 32'(n == 64));
        chk("s_empty", 32'(s_empty), 32'(n == 0));
        chk("f_empty", 32'(f_empty), 32'(n == 0));
        chk("s_almost_full", 32'(s_afull), 32'(n >= int'(afull_thresh)));
        chk("f_almost_full", 32'(f_afull), 32'(n >= int'(afull_thresh)));
        chk("s_almost_empty", 32'(s_aempty), 32'(n <= int'(aempty_thresh)));
        chk("f_almost_empty", 32'(f_aempty), 32'(n <= int'(aempty_thresh)));
        chk("s_overflow", 32'(s_ovf), 32'(ovf_m));
        chk("f_overflow", 32'(f_ovf), 32'(ovf_m));
        chk("s_underflow", 32'(s_udf), 32'(udf_m));
        chk("f_underflow", 32'(f_udf), 32'(udf_m));
        chk("s_rd_valid", 32'(s_rd_valid), 32'(sv_m));
        chk("s_rd_data", 32'(s_rd_data), 32'(sd_m));
        chk("f_rd_valid", 32'(f_rd_valid), 32'(n != 0));
        if (n != 0) begin
            chk("f_rd_data", 32'(f_rd_data), 32'(q[0]));
        end
    endtask

    // One clock cycle: drive, check the pre-edge state, advance the model.
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
        bit full_m;
        bit empty_m;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        @(negedge clk);
        check_all();
        full_m  = (q.size() == 64);
        empty_m = (q.size() == 0);
        if (w && full_m) ovf_m = 1'b1;
        else if (c) ovf_m = 1'b0;
        if (r && empty_m) udf_m = 1'b1;
        else if (c) udf_m = 1'b0;
        sv_m = 1'b0;
        if (r && !empty_m) begin
            sd_m = q.pop_front();
            sv_m = 1'b1;
        end
        if (w && !full_m) q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        #2;
        q.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
        sv_m  = 1'b0;
        sd_m  = 8'h00;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic fill_to(input int target);
        while (q.size() < target) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic drain_to(input int target);
        while (q.size() > target) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        int  written;
        int  n;
        bit  w;
        bit  r;

        wr_data       = 8'h00;
        afull_thresh  = 7'd0;
        aempty_thresh = 7'd4;
        apply_reset();
        afull_thresh  = 7'd60;

        // Fill with 0x00..0x3F, then one write too many.
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);

        // Drain in order, then one read too many; clear errors.
        for (int i = 0; i < 64; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Stream 200 random words with occupancy hovering around 10.
        written = 0;
        while (written < 200) begin
            n = q.size();
            w = (n < 8) || (n <= 12 && $urandom_range(0, 1) == 1);
            r = (n > 12) || (n >= 8 && $urandom_range(0, 1) == 1);
            step(w, 8'($urandom), r, 1'b0);
            if (w) written++;
        end
        drain_to(0);

        // Simultaneous read/write at mid, full and empty occupancy.
        fill_to(32);
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
        fill_to(64);
        step(1'b1, 8'($urandom), 1'b1, 1'b0);
        drain_to(0);
        step(1'b1, 8'($urandom), 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        drain_to(0);

        // Threshold behaviour, including a live threshold change.
        afull_thresh  = 7'd60;
        aempty_thresh = 7'd4;
        fill_to(55);
        afull_thresh = 7'd50;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        afull_thresh = 7'd60;
        fill_to(64);
        step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'($urandom), 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic with randomly moving thresholds.
        for (int i = 0; i < 150; i++) begin
            afull_thresh  = 7'($urandom_range(0, 64));
            aempty_thresh = 7'($urandom_range(0, 64));
            step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0);
        end
        afull_thresh  = 7'd60;
        aempty_thresh = 7'd4;

        // Reset in the middle of a write burst at level 20.
        drain_to(0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        fill_to(20);
        apply_reset();

        // Word written into an empty FIFO shows up on the FWFT head next cycle.
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("fwft_head_valid", 32'(f_rd_valid), 32'd1);
        chk("fwft_head_data", 32'(f_rd_data), 32'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
